// File: rtl/booth_radix4_multiplier_32_pkg.sv
// Shared widths, the Booth digit type and the triplet decoder used by the
// radix-4 multiplier and its partial-product generator.
package booth_radix4_multiplier_32_pkg;

  localparam int A_W    = 32;
  localparam int P_W    = 64;
  localparam int NUM_PP = 17;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  // Triplet is {B[2i+1], B[2i], B[2i-1]}.
  function automatic booth_digit_e decode_triplet(input logic [2:0] triplet);
    booth_digit_e digit;
    unique case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_radix4_multiplier_32_pp_gen.sv
// One radix-4 Booth partial product: digit x A at 64 bits, shifted left by 2*index.
module booth_radix4_pp_gen
  import booth_radix4_multiplier_32_pkg::*;
(
  input  logic [2:0]     i_triplet,
  input  logic [A_W-1:0] i_a,
  input  logic [4:0]     i_idx,
  output logic [P_W-1:0] o_pp
);

  booth_digit_e   w_digit;
  logic [P_W-1:0] w_a_ext;
  logic [P_W-1:0] w_mult;

  assign w_digit = decode_triplet(i_triplet);
  assign w_a_ext = {{(P_W - A_W){i_a[A_W-1]}}, i_a};

  // Negation happens after widening so -(-2^31) and -2*(-2^31) keep their magnitude.
  always_comb begin
    // NOTE: assign a default first so no path through the case leaves
    // w_mult unassigned, which would infer a latch.
    w_mult = '0;
    unique case (w_digit)
      POS1:    w_mult = w_a_ext;
      POS2:    w_mult = w_a_ext << 1;
      NEG1:    w_mult = -w_a_ext;
      NEG2:    w_mult = -(w_a_ext << 1);
      default: w_mult = '0;
    endcase
  end

  assign o_pp = w_mult << {i_idx, 1'b0};

endmodule

// File: rtl/booth_radix4_multiplier_32.sv
// 32x32 signed radix-4 Booth multiplier; partial products and their sum are
// formed combinationally and registered, giving one cycle of latency.
module booth_radix4_multiplier_32
  import booth_radix4_multiplier_32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [A_W-1:0]        A,
  input  logic [A_W-1:0]        B,
  output logic [P_W-1:0]        partial_products [0:NUM_PP-1],
  output logic [P_W-1:0]        P
);

  logic [2*NUM_PP:0] w_b_ext;
  logic [P_W-1:0]    w_pp [0:NUM_PP-1];
  logic [P_W-1:0]    w_sum;
  logic [P_W-1:0]    r_pp [0:NUM_PP-1];
  logic [P_W-1:0]    r_p;

  // Two sign copies on top, implicit B[-1] = 0 at the bottom.
  assign w_b_ext = {B[A_W-1], B[A_W-1], B, 1'b0};

  for (genvar g = 0; g < NUM_PP; g++) begin : g_pp
    booth_radix4_pp_gen u_pp_gen (
      .i_triplet (w_b_ext[2*g+2 -: 3]),
      .i_a       (A),
      .i_idx     (5'(g)),
      .o_pp      (w_pp[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_PP; k++) begin
      w_sum = w_sum + w_pp[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      for (int k = 0; k < NUM_PP; k++) begin
        r_pp[k] <= '0;
      end
    end else begin
      r_p <= w_sum;
      for (int k = 0; k < NUM_PP; k++) begin
        r_pp[k] <= w_pp[k];
      end
    end
  end

  assign P                = r_p;
  assign partial_products = r_pp;

endmodule

// File: tb/tb_booth_radix4_multiplier_32.sv
// Self-checking bench for booth_radix4_multiplier_32: directed vectors with
// hand-computed products, reset behaviour and back-to-back random operands.
module tb_booth_radix4_multiplier_32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] partial_products [0:16];
  logic [63:0] P;

  int n_checks = 0;
  int n_errors = 0;

  booth_radix4_multiplier_32 dut (
    .clk              (clk),
    .rst              (rst),
    .A                (A),
    .B                (B),
    .partial_products (partial_products),
    .P                (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pp_sum();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 17; k++) s = s + partial_products[k];
    return s;
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check(tag, P, exp);
    check({tag, "_ppsum"}, pp_sum(), exp);
  endtask

  initial begin
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        exp_p;
    logic [31:0]        ra;
    logic [31:0]        rb;

    rst = 1'b1;
    A   = 32'd7;
    B   = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    check("reset_p", P, 64'd0);
    for (int k = 0; k < 17; k++) check($sformatf("reset_pp%0d", k), partial_products[k], 64'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_p", P, 64'd63);

    // Outputs must not move before the capturing edge.
    @(negedge clk);
    A = 32'd15;
    B = 32'd3;
    #1;
    check("latency_hold", P, 64'd63);
    @(posedge clk);
    #1;
    check("p_15x3", P, 64'd45);
    check("pp0_15x3", partial_products[0], 64'hFFFF_FFFF_FFFF_FFF1);
    check("pp1_15x3", partial_products[1], 64'h0000_0000_0000_003C);
    for (int k = 2; k < 17; k++) check($sformatf("pp%0d_15x3", k), partial_products[k], 64'd0);

    run_vec("neg25x12",    32'hFFFF_FFE7, 32'd12,        64'hFFFF_FFFF_FFFF_FED4);
    run_vec("12345xm6789", 32'd12345,     -32'sd6789,    -64'sd83810205);
    run_vec("m1024xm2048", -32'sd1024,    -32'sd2048,    64'd2097152);
    run_vec("min_x_min",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_vec("max_x_min",   32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_vec("m1xm1",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    run_vec("max_x_max",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    run_vec("zero_x_min",  32'd0,         32'h8000_0000, 64'd0);

    // Mid-stream reset wipes the outputs on that very edge.
    @(negedge clk);
    rst = 1'b1;
    A   = 32'd100;
    B   = 32'd100;
    @(posedge clk);
    #1;
    check("midreset_p", P, 64'd0);
    check("midreset_pp16", partial_products[16], 64'd0);
    check("midreset_pp0", partial_products[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) ra = {ra[31], {31{ra[30]}}};
      if (i % 16 == 1) rb = {rb[31], {31{rb[30]}}};
      A  = ra;
      B  = rb;
      sa = $signed(ra);
      sb = $signed(rb);
      exp_p = sa * sb;
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_p", i), P, exp_p);
      check($sformatf("rand%0d_ppsum", i), pp_sum(), P);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
